bar_graph_renderer: RTL and testbench

Parametrised spectrum bar renderer for the audio visualiser VGA path: accepts per-bar magnitude writes from the FFT/magnitude stage, latches them once per frame, and draws N vertical bars bottom-up with falling-bar decay and a held peak marker. Sits between the magnitude stage and the VGA controller, consuming DrawX/DrawY and producing registered 8-bit RGB.

---
 rtl/bar_graph_pkg.sv | 25 ++
 rtl/bar_graph_renderer_bar_state.sv | 62 ++++++
 rtl/bar_graph_renderer.sv | 104 ++++++++++
 tb/tb_bar_graph_renderer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bar_graph_pkg.sv
// Shared types and colours for the spectrum bar renderer.
// Colour constants and the vertical zone palette.
package bar_graph_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t BG     = '{8'h00, 8'h00, 8'h80};
  localparam rgb_t RED    = '{8'hFF, 8'h00, 8'h00};
  localparam rgb_t YELLOW = '{8'hFF, 8'hFF, 8'h00};
  localparam rgb_t GREEN  = '{8'h00, 8'hFF, 8'h00};
  localparam rgb_t WHITE  = '{8'hFF, 8'hFF, 8'hFF};
  localparam rgb_t BLACK  = '{8'h00, 8'h00, 8'h00};

  // Top quarter red, next quarter yellow, lower half green.
  function automatic rgb_t zone_colour(input int y, input int h_max);
    if (y < h_max / 4) return RED;
    if (y < h_max / 2) return YELLOW;
    return GREEN;
  endfunction

endpackage

// File: rtl/bar_graph_renderer_bar_state.sv
// Per-bar state: pending write, displayed height, peak marker.
// Heights fall by DECAY_STEP per frame; peaks hold, then sink.
module bar_state #(
  parameter int H_MAX      = 480,
  parameter int H_W        = 9,
  parameter int DECAY_STEP = 2,
  parameter int PEAK_HOLD  = 30
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [H_W-1:0] wr_data,
  input  logic           frame_start,
  output logic [H_W-1:0] height,
  output logic [H_W-1:0] peak
);

  localparam int HOLD_W = $clog2(PEAK_HOLD + 1);

  logic [H_W-1:0]    pending;
  logic [H_W-1:0]    decayed;
  logic [H_W-1:0]    height_new;
  logic [HOLD_W-1:0] hold;

  // Height candidate for the next frame.
  always_comb begin
    decayed = '0;
    if (int'(height) >= DECAY_STEP)
      decayed = height - H_W'(DECAY_STEP);
    height_new = (pending > decayed) ? pending : decayed;
  end

  // A write in the frame_start cycle lands in the cleared slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= '0;
    else if (wr_en)
      pending <= wr_data;
    else if (frame_start)
      pending <= '0;
  end

  // Once-per-frame height and peak update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      height <= '0;
      peak   <= '0;
      hold   <= '0;
    end else if (frame_start) begin
      height <= height_new;
      if (height_new >= peak) begin
        peak <= height_new;
        hold <= HOLD_W'(PEAK_HOLD);
      end else if (hold != '0) begin
        hold <= hold - HOLD_W'(1);
      end else if (peak != '0) begin
        peak <= peak - H_W'(1);
      end
    end
  end

endmodule

// File: rtl/bar_graph_renderer.sv
// Spectrum bar renderer: latches magnitudes per frame and
// draws bottom-up bars with decay and a held peak marker.
module bar_graph_renderer
  import bar_graph_pkg::*;
#(
  parameter int N_BARS     = 10,
  parameter int BAR_W      = 53,
  parameter int BAR_GAP    = 10,
  parameter int X0         = 10,
  parameter int H_MAX      = 480,
  parameter int H_W        = $clog2(H_MAX + 1),
  parameter int DECAY_STEP = 2,
  parameter int PEAK_HOLD  = 30
) (
  input  logic              MAX10_CLK1_50,
  input  logic              Reset,
  input  logic              pixel_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic              mag_valid,
  input  logic [3:0]        mag_idx,
  input  logic [H_W-1:0]    mag_data,
  input  logic [N_BARS-1:0] bar_en,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B
);

  localparam int PITCH = BAR_W + BAR_GAP;

  logic [H_W-1:0]    mag_clamped;
  logic [N_BARS-1:0] wr_hit;
  logic [N_BARS-1:0] in_x;
  logic [H_W-1:0]    height [N_BARS];
  logic [H_W-1:0]    peak   [N_BARS];
  logic              frame_seen;
  rgb_t              pix;
  rgb_t              rgb_q;

  assign mag_clamped = (int'(mag_data) > H_MAX) ? H_W'(H_MAX) : mag_data;

  for (genvar i = 0; i < N_BARS; i++) begin : g_bar
    localparam int XS = X0 + i * PITCH;
    localparam int XE = XS + BAR_W - 1;

    assign wr_hit[i] = mag_valid && (int'(mag_idx) == i);
    assign in_x[i]   = bar_en[i] && (int'(DrawX) >= XS) && (int'(DrawX) <= XE);

    bar_state #(
      .H_MAX      (H_MAX),
      .H_W        (H_W),
      .DECAY_STEP (DECAY_STEP),
      .PEAK_HOLD  (PEAK_HOLD)
    ) u_state (
      .clk         (MAX10_CLK1_50),
      .rst_n       (Reset),
      .wr_en       (wr_hit[i]),
      .wr_data     (mag_clamped),
      .frame_start (frame_start),
      .height      (height[i]),
      .peak        (peak[i])
    );
  end

  // Nothing is drawn until a frame has been latched after reset.
  always_ff @(posedge MAX10_CLK1_50 or negedge Reset) begin
    if (!Reset)
      frame_seen <= 1'b0;
    else if (frame_start)
      frame_seen <= 1'b1;
  end

  // Priority colour: off-screen, peak marker, bar zone, background.
  always_comb begin
    pix = BG;
    if (!frame_seen || int'(DrawX) >= 640 || int'(DrawY) >= H_MAX) begin
      pix = BLACK;
    end else begin
      for (int i = 0; i < N_BARS; i++) begin
        if (in_x[i]) begin
          if (peak[i] != '0 && int'(peak[i]) < H_MAX &&
              int'(DrawY) + int'(peak[i]) == H_MAX - 1)
            pix = WHITE;
          else if (int'(DrawY) + int'(height[i]) >= H_MAX)
            pix = zone_colour(int'(DrawY), H_MAX);
        end
      end
    end
  end

  // Registered colour, held between pixel strobes.
  always_ff @(posedge MAX10_CLK1_50 or negedge Reset) begin
    if (!Reset)
      rgb_q <= BLACK;
    else if (pixel_en)
      rgb_q <= pix;
  end

  assign VGA_R = rgb_q.r;
  assign VGA_G = rgb_q.g;
  assign VGA_B = rgb_q.b;

endmodule

// File: tb/tb_bar_graph_renderer.sv
// Directed bench for bar_graph_renderer.
// Expected colours are hand-derived from bar geometry.
module tb_bar_graph_renderer;

  localparam logic [23:0] C_BG = 24'h000080;
  localparam logic [23:0] C_R  = 24'hFF0000;
  localparam logic [23:0] C_Y  = 24'hFFFF00;
  localparam logic [23:0] C_G  = 24'h00FF00;
  localparam logic [23:0] C_W  = 24'hFFFFFF;
  localparam logic [23:0] C_K  = 24'h000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pixel_en = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       frame_start = 1'b0;
  logic       mag_valid = 1'b0;
  logic [3:0] mag_idx = '0;
  logic [8:0] mag_data = '0;
  logic [9:0] bar_en = '1;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  int total = 0;
  int bad = 0;
  logic [23:0] got;

  bar_graph_renderer dut (
    .MAX10_CLK1_50 (clk),
    .Reset         (rst_n),
    .pixel_en      (pixel_en),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .frame_start   (frame_start),
    .mag_valid     (mag_valid),
    .mag_idx       (mag_idx),
    .mag_data      (mag_data),
    .bar_en        (bar_en),
    .VGA_R         (VGA_R),
    .VGA_G         (VGA_G),
    .VGA_B         (VGA_B)
  );

  always #10 clk = ~clk;

  task automatic draw(input int x, input int y);
    @(negedge clk);
    pixel_en = 1'b1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(negedge clk);
    pixel_en = 1'b0;
    got = {VGA_R, VGA_G, VGA_B};
  endtask

  task automatic frame(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
  endtask

  task automatic wr(input int idx, input int data);
    @(negedge clk);
    mag_valid = 1'b1;
    mag_idx = 4'(idx);
    mag_data = 9'(data);
    @(negedge clk);
    mag_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {VGA_R, VGA_G, VGA_B};
    total++;
    if (got !== C_K) begin
      bad++;
      $display("FAIL reset_out got=%06h exp=%06h", got, C_K);
    end
    rst_n = 1'b1;
    draw(10, 479);
    total++;
    if (got !== C_K) begin
      bad++;
      $display("FAIL reset_preframe got=%06h exp=%06h", got, C_K);
    end
    frame(1);
    draw(10, 479);
    total++;
    if (got !== C_BG) begin
      bad++;
      $display("FAIL reset_bg got=%06h exp=%06h", got, C_BG);
    end
  endtask

  task automatic test_single_bar();
    int xs [8] = '{10, 10, 10, 10, 62, 63, 73, 9};
    int ys [8] = '{479, 380, 379, 378, 479, 479, 479, 479};
    logic [23:0] ex [8] = '{C_G, C_G, C_W, C_BG, C_G, C_BG, C_BG, C_BG};
    wr(0, 100);
    frame(1);
    for (int k = 0; k < 8; k++) begin
      draw(xs[k], ys[k]);
      total++;
      if (got !== ex[k]) begin
        bad++;
        $display("FAIL single_bar[%0d] (%0d,%0d) got=%06h exp=%06h",
                 k, xs[k], ys[k], got, ex[k]);
      end
    end
    draw(10, 479);
    repeat (3) @(negedge clk);
    got = {VGA_R, VGA_G, VGA_B};
    total++;
    if (got !== C_G) begin
      bad++;
      $display("FAIL hold_output got=%06h exp=%06h", got, C_G);
    end
  endtask

  task automatic test_decay();
    int xs [9] = '{10, 10, 10, 10, 10, 10, 10, 10, 10};
    int ys [9] = '{390, 389, 379, 379, 380, 380, 379, 381, 380};
    logic [23:0] ex [9] = '{C_G, C_BG, C_W, C_W, C_BG, C_W, C_BG, C_W, C_BG};
    int step [9] = '{5, 0, 0, 25, 0, 1, 0, 1, 0};
    for (int k = 0; k < 9; k++) begin
      frame(step[k]);
      draw(xs[k], ys[k]);
      total++;
      if (got !== ex[k]) begin
        bad++;
        $display("FAIL decay[%0d] (%0d,%0d) got=%06h exp=%06h",
                 k, xs[k], ys[k], got, ex[k]);
      end
    end
  endtask

  task automatic test_simultaneous();
    int xs [6] = '{136, 136, 136, 188, 189, 135};
    int ys [6] = '{280, 279, 281, 479, 479, 479};
    logic [23:0] ex [6] = '{C_G, C_W, C_G, C_G, C_BG, C_BG};
    @(negedge clk);
    frame_start = 1'b1;
    mag_valid = 1'b1;
    mag_idx = 4'd2;
    mag_data = 9'd200;
    @(negedge clk);
    frame_start = 1'b0;
    mag_valid = 1'b0;
    draw(136, 479);
    total++;
    if (got !== C_BG) begin
      bad++;
      $display("FAIL simul_absent got=%06h exp=%06h", got, C_BG);
    end
    frame(1);
    for (int k = 0; k < 6; k++) begin
      draw(xs[k], ys[k]);
      total++;
      if (got !== ex[k]) begin
        bad++;
        $display("FAIL simul[%0d] (%0d,%0d) got=%06h exp=%06h",
                 k, xs[k], ys[k], got, ex[k]);
      end
    end
  endtask

  task automatic test_clamp();
    int xs [9] = '{73, 73, 73, 73, 73, 73, 262, 640, 73};
    int ys [9] = '{0, 119, 120, 239, 240, 479, 479, 479, 480};
    logic [23:0] ex [9] = '{C_R, C_R, C_Y, C_Y, C_G, C_G, C_BG, C_K, C_K};
    wr(12, 300);
    wr(1, 500);
    frame(1);
    for (int k = 0; k < 9; k++) begin
      draw(xs[k], ys[k]);
      total++;
      if (got !== ex[k]) begin
        bad++;
        $display("FAIL clamp[%0d] (%0d,%0d) got=%06h exp=%06h",
                 k, xs[k], ys[k], got, ex[k]);
      end
    end
  endtask

  task automatic test_bar_en();
    int xs [9] = '{199, 251, 225, 252, 199, 199, 199, 251, 251};
    int ys [9] = '{479, 200, 179, 479, 479, 180, 179, 300, 178};
    logic [23:0] ex [9] = '{C_BG, C_BG, C_BG, C_BG, C_G, C_Y, C_W, C_G, C_BG};
    bar_en[3] = 1'b0;
    wr(3, 300);
    frame(1);
    for (int k = 0; k < 9; k++) begin
      if (k == 4) bar_en[3] = 1'b1;
      draw(xs[k], ys[k]);
      total++;
      if (got !== ex[k]) begin
        bad++;
        $display("FAIL bar_en[%0d] (%0d,%0d) got=%06h exp=%06h",
                 k, xs[k], ys[k], got, ex[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    draw(199, 479);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {VGA_R, VGA_G, VGA_B};
    total++;
    if (got !== C_K) begin
      bad++;
      $display("FAIL midreset_out got=%06h exp=%06h", got, C_K);
    end
    @(negedge clk);
    rst_n = 1'b1;
    draw(199, 479);
    total++;
    if (got !== C_K) begin
      bad++;
      $display("FAIL midreset_black got=%06h exp=%06h", got, C_K);
    end
    frame(1);
    draw(199, 479);
    total++;
    if (got !== C_BG) begin
      bad++;
      $display("FAIL midreset_cleared got=%06h exp=%06h", got, C_BG);
    end
  endtask

  initial begin
    test_reset();
    test_single_bar();
    test_decay();
    test_simultaneous();
    test_clamp();
    test_bar_en();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
